// File: rtl/toi2s_pkg.sv
// rtl/toi2s_pkg.sv - shared command codes and state types for the SPI register-bus bridge
package toi2s_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h80;
    localparam logic [7:0] CMD_READ  = 8'h00;

    typedef enum logic [2:0] {
        F_IDLE,
        F_CMD,
        F_ADDR,
        F_WDATA,
        F_RDATA,
        F_IGNORE
    } frame_state_t;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_WR,
        BUS_RD_ADDR,
        BUS_RD_CAP
    } bus_state_t;

endpackage

// File: rtl/spi_rb_master_if.sv
// rtl/spi_rb_master_if.sv - register-bus connection between the SPI bridge and the register bank
interface spi_rb_master_if #(
    parameter int ADR_BITS = 8
) ();

    logic [ADR_BITS-1:0] rb_address;
    logic [7:0]          rb_data_write;
    logic [7:0]          rb_data_read;
    logic                rb_reg_en;
    logic                rb_write_en;

    modport master (
        output rb_address,
        output rb_data_write,
        output rb_reg_en,
        output rb_write_en,
        input  rb_data_read
    );

    modport slave (
        input  rb_address,
        input  rb_data_write,
        input  rb_reg_en,
        input  rb_write_en,
        output rb_data_read
    );

endinterface

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - synchronizes sclk/csn/mosi and produces registered edge pulses
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetb,
    input  logic spi_sclk,
    input  logic spi_csn,
    input  logic spi_mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csn_fall,
    output logic csn_rise,
    output logic csn_l,
    output logic mosi_l
);

    logic [SYNC_STAGES-1:0] sclk_sh;
    logic [SYNC_STAGES-1:0] csn_sh;
    logic [SYNC_STAGES-1:0] mosi_sh;
    logic [SYNC_STAGES-1:0] vld_sh;
    logic                   sclk_s;
    logic                   csn_s;
    logic                   mosi_s;
    logic                   vld_s;
    logic                   sclk_d;
    logic                   csn_d;
    logic                   csn_d_vld;

    assign sclk_s = sclk_sh[SYNC_STAGES-1];
    assign csn_s  = csn_sh[SYNC_STAGES-1];
    assign mosi_s = mosi_sh[SYNC_STAGES-1];
    assign vld_s  = vld_sh[SYNC_STAGES-1];

    // vld_sh marks when the csn chain holds real pin samples, so a csn held low
    // across reset never looks like a fresh falling edge.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sclk_sh   <= '0;
            csn_sh    <= '1;
            mosi_sh   <= '0;
            vld_sh    <= '0;
            sclk_d    <= 1'b0;
            csn_d     <= 1'b1;
            csn_d_vld <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            csn_fall  <= 1'b0;
            csn_rise  <= 1'b0;
            csn_l     <= 1'b1;
            mosi_l    <= 1'b0;
        end else begin
            sclk_sh   <= {sclk_sh[SYNC_STAGES-2:0], spi_sclk};
            csn_sh    <= {csn_sh[SYNC_STAGES-2:0], spi_csn};
            mosi_sh   <= {mosi_sh[SYNC_STAGES-2:0], spi_mosi};
            vld_sh    <= {vld_sh[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_s;
            csn_d     <= csn_s;
            csn_d_vld <= vld_s;
            sclk_rise <= sclk_s & ~sclk_d;
            sclk_fall <= ~sclk_s & sclk_d;
            csn_fall  <= csn_d_vld & csn_d & ~csn_s;
            csn_rise  <= csn_s & ~csn_d;
            csn_l     <= csn_s;
            mosi_l    <= mosi_s;
        end
    end

endmodule

// File: rtl/spi_rb_master.sv
// rtl/spi_rb_master.sv - SPI mode-0 slave that turns command/address/data bytes into register-bus accesses
module spi_rb_master
    import toi2s_pkg::*;
#(
    parameter int ADR_BITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            resetb,
    input  logic            spi_sclk,
    input  logic            spi_csn,
    input  logic            spi_mosi,
    output logic            spi_miso,
    output logic            spi_miso_oe,
    spi_rb_master_if.master rb
);

    logic                sclk_rise;
    logic                sclk_fall;
    logic                csn_fall;
    logic                csn_rise;
    logic                csn_l;
    logic                mosi_l;

    frame_state_t        frame_q;
    frame_state_t        frame_d;
    bus_state_t          bus_q;
    bus_state_t          bus_d;

    logic [2:0]          bit_cnt;
    logic [7:0]          rx_shift;
    logic [7:0]          rx_byte;
    logic [7:0]          tx_shift;
    logic [7:0]          wdata_q;
    logic [ADR_BITS-1:0] addr_q;
    logic                cmd_rd;
    logic                byte_done;
    logic                wr_req;
    logic                rd_req;
    logic                addr_load;

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .resetb    (resetb),
        .spi_sclk  (spi_sclk),
        .spi_csn   (spi_csn),
        .spi_mosi  (spi_mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .csn_fall  (csn_fall),
        .csn_rise  (csn_rise),
        .csn_l     (csn_l),
        .mosi_l    (mosi_l)
    );

    assign rx_byte   = {rx_shift[6:0], mosi_l};
    assign byte_done = sclk_rise & ~csn_l & (bit_cnt == 3'd7) & (frame_q != F_IDLE);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            frame_q <= F_IDLE;
            bus_q   <= BUS_IDLE;
        end else begin
            frame_q <= frame_d;
            bus_q   <= bus_d;
        end
    end

    always_comb begin
        frame_d   = frame_q;
        wr_req    = 1'b0;
        rd_req    = 1'b0;
        addr_load = 1'b0;
        if (csn_l) begin
            frame_d = F_IDLE;
        end else begin
            case (frame_q)
                F_IDLE: begin
                    if (csn_fall) frame_d = F_CMD;
                end
                F_CMD: begin
                    if (byte_done) begin
                        if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) frame_d = F_ADDR;
                        else                                             frame_d = F_IGNORE;
                    end
                end
                F_ADDR: begin
                    if (byte_done) begin
                        addr_load = 1'b1;
                        rd_req    = cmd_rd;
                        frame_d   = cmd_rd ? F_RDATA : F_WDATA;
                    end
                end
                F_WDATA: wr_req = byte_done;
                F_RDATA: rd_req = byte_done;
                default: ;
            endcase
        end
    end

    // The bus FSM ignores csn entirely so an issued access always finishes.
    always_comb begin
        bus_d = bus_q;
        case (bus_q)
            BUS_IDLE: begin
                if (wr_req)      bus_d = BUS_WR;
                else if (rd_req) bus_d = BUS_RD_ADDR;
            end
            BUS_WR:      bus_d = BUS_IDLE;
            BUS_RD_ADDR: bus_d = BUS_RD_CAP;
            default:     bus_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
            tx_shift <= 8'h00;
            wdata_q  <= 8'h00;
            addr_q   <= '0;
            cmd_rd   <= 1'b0;
        end else begin
            if (csn_fall)                  bit_cnt <= 3'd0;
            else if (sclk_rise && !csn_l)  bit_cnt <= bit_cnt + 3'd1;

            if (sclk_rise && !csn_l) rx_shift <= rx_byte;

            if (csn_rise)                              cmd_rd <= 1'b0;
            else if (frame_q == F_CMD && byte_done)    cmd_rd <= (rx_byte == CMD_READ);

            if (wr_req) wdata_q <= rx_byte;

            if (addr_load)
                addr_q <= ADR_BITS'(rx_byte);
            else if (bus_q == BUS_WR || bus_q == BUS_RD_CAP)
                addr_q <= addr_q + ADR_BITS'(1);

            // No shift on the fall that closes a byte (bit_cnt wrapped to 0): that
            // slot belongs to the freshly loaded MSB of the next byte.
            if (bus_q == BUS_RD_CAP)
                tx_shift <= rb.rb_data_read;
            else if (csn_fall)
                tx_shift <= 8'h00;
            else if (sclk_fall && !csn_l && bit_cnt != 3'd0)
                tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end

    assign spi_miso       = tx_shift[7] & (frame_q != F_IGNORE);
    assign spi_miso_oe    = ~csn_l;
    assign rb.rb_address    = addr_q;
    assign rb.rb_data_write = wdata_q;
    assign rb.rb_reg_en     = (bus_q != BUS_IDLE);
    assign rb.rb_write_en   = (bus_q == BUS_WR);

endmodule
